// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared defaults and FSM state type for the store buffer.
package store_buffer_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;
  typedef enum logic {IDLE, ISSUE} state_e;
endpackage

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: circular entry storage with pointers and occupancy count.
// STORE_BUFFER_COALESCE_EN adds in-place data overwrite of the youngest entry.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
`ifdef STORE_BUFFER_COALESCE_EN
  input  logic                     coal,
  output logic [ADDR_W-1:0]        tail_addr,
`endif
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - PW'(1);
  assign tail_addr = addr_mem[tail_ptr];
`endif
  // Storage is left uninitialised; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    else if (coal) data_mem[tail_ptr] <= wr_data;
`endif
  end
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: CPU store FIFO draining to data memory through an IDLE/ISSUE FSM.
// Define STORE_BUFFER_COALESCE_EN to merge same-address stores into the youngest entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_drop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic st_drop_q, st_drop_d;
  logic push, pop, coal;
`ifdef STORE_BUFFER_COALESCE_EN
  logic [ADDR_W-1:0] tail_addr;
`endif
  store_buffer_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
`ifdef STORE_BUFFER_COALESCE_EN
    .coal     (coal),
    .tail_addr(tail_addr),
`endif
    .wr_addr  (st_addr),
    .wr_data  (st_data),
    .head_addr(mem_addr),
    .head_data(mem_wdata),
    .count    (count)
  );
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign mem_req = state_q == ISSUE;
  assign busy = !(empty && state_q == IDLE);
  assign pop = mem_req && mem_ack;
  assign st_drop = st_drop_q;
  always_comb begin
`ifdef STORE_BUFFER_COALESCE_EN
    // The head is frozen while being issued, so it must never be rewritten.
    coal = st_valid && !empty && st_addr == tail_addr && !(mem_req && count == CW'(1));
`else
    coal = 1'b0;
`endif
    push = st_valid && !full && !coal;
    st_drop_d = st_valid && full && !coal;
    state_d = state_q == IDLE ? (empty ? IDLE : ISSUE)
                              : ((pop && count == CW'(1) && !push) ? IDLE : ISSUE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      st_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_drop_q <= st_drop_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a scoreboard of expected memory writes.
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic st_valid = 1'b0;
  logic [7:0] st_addr = '0;
  logic [7:0] st_data = '0;
  logic mem_ack = 1'b0;
  logic st_drop, full, empty, busy, mem_req;
  logic [2:0] count;
  logic [7:0] mem_addr, mem_wdata;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q [$];

  store_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_drop(st_drop), .full(full), .empty(empty),
    .count(count), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
  endtask

  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL mem_write: got %02h/%02h expected none", mem_addr, mem_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} != e) begin
          mismatched++;
          $display("FAIL mem_write: got %02h/%02h expected %02h/%02h",
                   mem_addr, mem_wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    int n, first, last;
    cyc();
    cyc();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_st_drop", st_drop, 0);

    // single store, ack held high from the start
    reset = 1'b0;
    mem_ack = 1'b1;
    store(8'h10, 8'hAA);
    exp_q.push_back(16'h10AA);
    cyc();
    st_valid = 1'b0;
    chk("lat_c1_req", mem_req, 0);
    chk("lat_c1_count", count, 1);
    cyc();
    chk("lat_c2_req", mem_req, 1);
    cyc();
    chk("lat_c3_empty", empty, 1);
    chk("lat_c3_req", mem_req, 0);
    mem_ack = 1'b0;

    // five stores without ack: fifth rejected
    for (int i = 0; i < 5; i++) begin
      store(8'h30 + 8'(i), 8'h40 + 8'(i));
      if (i < 4) exp_q.push_back({8'h30 + 8'(i), 8'h40 + 8'(i)});
      cyc();
      if (i == 3) chk("full_after_4", full, 1);
    end
    st_valid = 1'b0;
    chk("drop_pulse", st_drop, 1);
    chk("count_full", count, 4);
    chk("head_stable", mem_addr, 8'h30);
    cyc();
    chk("drop_clear", st_drop, 0);

    // full buffer: store and ack on the same edge
    store(8'h99, 8'h77);
    mem_ack = 1'b1;
    cyc();
    st_valid = 1'b0;
    mem_ack = 1'b0;
    chk("same_edge_drop", st_drop, 1);
    chk("same_edge_count", count, 3);
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    mem_ack = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_busy", busy, 0);

    // four queued stores drained back to back
    for (int i = 0; i < 4; i++) begin
      store(8'h50 + 8'(i), 8'hA0 + 8'(i));
      exp_q.push_back({8'h50 + 8'(i), 8'hA0 + 8'(i)});
      cyc();
    end
    st_valid = 1'b0;
    cyc();
    mem_ack = 1'b1;
    n = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 10; k++) begin
      if (mem_req) begin
        n++;
        if (first < 0) first = k;
        last = k;
      end
      cyc();
    end
    mem_ack = 1'b0;
    chk("b2b_cycles", n, 4);
    chk("b2b_span", last - first, 3);
    chk("b2b_idle", busy, 0);

    // reset while issuing, with a store competing
    for (int i = 0; i < 3; i++) begin
      store(8'h70 + 8'(i), 8'h01);
      cyc();
    end
    st_valid = 1'b0;
    cyc();
    chk("pre_rst_req", mem_req, 1);
    reset = 1'b1;
    mem_ack = 1'b1;
    store(8'h7F, 8'h02);
    exp_q.delete();
    cyc();
    reset = 1'b0;
    st_valid = 1'b0;
    mem_ack = 1'b0;
    chk("rst_issue_req", mem_req, 0);
    chk("rst_issue_count", count, 0);
    chk("rst_issue_busy", busy, 0);

    // same-address stores behind a busy head
    store(8'h60, 8'h11);
    exp_q.push_back(16'h6011);
    cyc();
    store(8'h20, 8'h01);
    cyc();
    store(8'h20, 8'h02);
    cyc();
    st_valid = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
    exp_q.push_back(16'h2002);
    chk("coal_count", count, 2);
`else
    exp_q.push_back(16'h2001);
    exp_q.push_back(16'h2002);
    chk("coal_count", count, 3);
`endif
    chk("coal_drop", st_drop, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    mem_ack = 1'b0;
    chk("final_empty", empty, 1);
    chk("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries; power of 2, >= 2.
REQ-002 SHALL have parameter ADDR_W, default 8, store address width.
REQ-003 SHALL have parameter DATA_W, default 8, store data width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port st_valid  input  1  store request from the CPU core (its store output).
REQ-007 SHALL have port st_addr  input  ADDR_W  store address (CPU address output).
REQ-008 SHALL have port st_data  input  DATA_W  store data (CPU out_data output).
REQ-009 SHALL have port st_drop  output  1  registered one-cycle pulse: the previous cycle's store was rejected.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port empty  output  1  count == 0.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port busy  output  1  high unless empty and FSM in IDLE.
REQ-014 SHALL have port mem_req  output  1  registered write request to data memory.
REQ-015 SHALL have port mem_addr  output  ADDR_W  head entry address.
REQ-016 SHALL have port mem_wdata  output  DATA_W  head entry data.
REQ-017 SHALL have port mem_ack  input  1  memory accepted the write this cycle.

Function
REQ-018 SHALL enqueue {st_addr, st_data} at the tail on a rising edge where st_valid=1 and full=0.
REQ-019 SHALL reject a store when st_valid=1 and full=1 (full evaluated from the pre-edge count, even if a pop occurs on the same edge), and SHALL assert st_drop for exactly the following cycle.
REQ-020 SHALL implement FSM states IDLE and ISSUE; IDLE->ISSUE when count>0; ISSUE->IDLE on mem_ack when count after the pop is 0; otherwise remain in ISSUE.
REQ-021 SHALL drive mem_req=1 exactly while in ISSUE; mem_addr/mem_wdata SHALL equal the head entry and remain stable until mem_ack.
REQ-022 SHALL sample mem_ack only while mem_req=1; mem_ack while mem_req=0 SHALL be ignored.
REQ-023 SHALL pop the head on the edge with mem_req=1 and mem_ack=1; with entries remaining, mem_req SHALL stay high and present the next head in the next cycle (back-to-back, no bubble).
REQ-024 SHALL assert mem_req in the second cycle after a store is presented to an empty, idle buffer (st_valid in cycle 0 -> mem_req in cycle 2).
REQ-025 SHALL apply simultaneous push and pop in the same edge, leaving count unchanged.
REQ-026 SHALL wrap read/write pointers modulo DEPTH and issue stores strictly in FIFO order.

Reset
REQ-027 SHALL, on reset, clear count and both pointers, force IDLE, and drive mem_req=0, st_drop=0, empty=1, full=0, busy=0; entry storage need not be cleared.
REQ-028 SHALL, on reset during ISSUE, abandon the in-flight write and discard all entries; reset SHALL take priority over st_valid and mem_ack.

Configuration
REQ-029 SHALL, with STORE_BUFFER_COALESCE_EN defined, overwrite the youngest entry's data in place (count unchanged, accepted even when full, no st_drop) when st_valid=1, count>0, st_addr equals that entry's address, and that entry is not the head while in ISSUE.
REQ-030 SHALL, without STORE_BUFFER_COALESCE_EN, allocate a new entry for every accepted store; the port list SHALL be identical in both builds.

Structure
REQ-031 SHALL take ADDR_W/DATA_W/DEPTH defaults and the FSM state enum from shared package store_buffer_pkg.
REQ-032 SHALL place entry storage, pointers and count in sub-module store_buffer_fifo; the FSM, drop logic and coalesce logic SHALL reside in store_buffer.

Verification
REQ-033 SHALL cover: store (0x10,0xAA) into empty buffer, mem_ack held high -> mem_req in cycle 2 with addr 0x10/data 0xAA, empty=1 one cycle after the ack.
REQ-034 SHALL cover: 5 stores with mem_ack=0, DEPTH=4 -> full=1 after the 4th, 5th rejected, st_drop pulses one cycle, count=4.
REQ-035 SHALL cover: 4 queued stores, mem_ack held 1 -> four consecutive mem_req cycles in order, then IDLE.
REQ-036 SHALL cover: full buffer, st_valid and mem_ack on the same edge -> store dropped, count=3.
REQ-037 SHALL cover: reset asserted during ISSUE with 3 entries -> next cycle mem_req=0, count=0, busy=0.
REQ-038 SHALL cover: with coalescing enabled, stores (0x20,0x01) then (0x20,0x02) while head busy -> count=2, second entry data 0x02; disabled build -> count=3.
